ring_gate_counter: RTL and testbench

//  Multi-channel gated edge counter (ring-oscillator frequency meter).

---
 rtl/ring_gate_counter.sv | 125 ++++++++++++
 tb/tb_ring_gate_counter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_gate_counter.sv
// ring_gate_counter: counts rising edges of N_CH asynchronous ring-oscillator lines over a gate of clk cycles.
// Define RING_CNT_HANDSHAKE_EN to make valid a level cleared by ack, with a sticky lost flag.
module ring_gate_counter #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int GATE_W  = 16,
  parameter int SYNC_FF = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       ring_in,
  input  logic                  start,
  input  logic                  mode,
  input  logic [GATE_W-1:0]     gate_len,
`ifdef RING_CNT_HANDSHAKE_EN
  input  logic                  ack,
  output logic                  lost,
`endif
  output logic [N_CH*CNT_W-1:0] value_out,
  output logic [N_CH-1:0]       overflow,
  output logic                  valid,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_reg, state_next;
  logic [GATE_W-1:0] len_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic              mode_reg;
  logic              win_start;
  logic              latch_exit;
  logic [N_CH-1:0]   rise;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = GATE;
      GATE:    if (gate_cnt_reg == len_reg - GATE_W'(1)) state_next = LATCH;
      // Continuing needs both the window's latched mode and the live mode, so clearing mode stops after this window.
      LATCH:   state_next = (mode_reg && mode) ? GATE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign win_start  = (state_next == GATE) && (state_reg != GATE);
  assign latch_exit = (state_reg == LATCH);
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= GATE_W'(1);
      gate_cnt_reg <= '0;
      mode_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (win_start) begin
        len_reg      <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        mode_reg     <= mode;
        gate_cnt_reg <= '0;
      end else if (state_reg == GATE) begin
        gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
      end
    end
  end

  logic [SYNC_FF-1:0] sync_reg  [N_CH];
  logic               prev_reg  [N_CH];
  logic [CNT_W-1:0]   cnt_reg   [N_CH];
  logic [CNT_W-1:0]   value_reg [N_CH];
  logic               ovf_reg   [N_CH];
  logic               ovf_out_reg [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign rise[gi] = sync_reg[gi][SYNC_FF-1] & ~prev_reg[gi];
    assign value_out[gi*CNT_W +: CNT_W] = value_reg[gi];
    assign overflow[gi] = ovf_out_reg[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_reg[gi]    <= '0;
        prev_reg[gi]    <= 1'b0;
        cnt_reg[gi]     <= '0;
        ovf_reg[gi]     <= 1'b0;
        value_reg[gi]   <= '0;
        ovf_out_reg[gi] <= 1'b0;
      end else begin
        sync_reg[gi] <= {sync_reg[gi][SYNC_FF-2:0], ring_in[gi]};
        prev_reg[gi] <= sync_reg[gi][SYNC_FF-1];
        if (latch_exit) begin
          value_reg[gi]   <= cnt_reg[gi];
          ovf_out_reg[gi] <= ovf_reg[gi];
        end
        if (win_start || latch_exit) begin
          cnt_reg[gi] <= '0;
          ovf_reg[gi] <= 1'b0;
        end else if (state_reg == GATE && rise[gi]) begin
          if (cnt_reg[gi] == CNT_MAX) ovf_reg[gi] <= 1'b1;
          else                        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  end

`ifdef RING_CNT_HANDSHAKE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      lost  <= 1'b0;
    end else if (latch_exit) begin
      valid <= 1'b1;
      lost  <= ack ? 1'b0 : (lost | valid);
    end else if (ack) begin
      valid <= 1'b0;
      lost  <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= 1'b0;
    else        valid <= latch_exit;
  end
`endif
endmodule

// File: tb/tb_ring_gate_counter.sv
// Bench for ring_gate_counter: a 16-bit and a 4-bit instance share random ring stimulus and are
// checked against a model that counts recorded ring rises falling inside each gate window.
`timescale 1ns/1ps
module tb_ring_gate_counter;
  localparam int SYNC_FF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ring = 2'b00;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] gate_len = 16'd0;
  logic        ack = 1'b1;
  logic [31:0] value_out;
  logic [1:0]  overflow;
  logic        valid, busy;
  logic [7:0]  value_sat;
  logic [1:0]  ovf_sat;
  logic        valid_sat, busy_sat;
`ifdef RING_CNT_HANDSHAKE_EN
  logic        lost, lost_sat;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int period [2] = '{0, 0};
  int ph [2] = '{0, 0};
  int rises0 [$];
  int rises1 [$];
  logic ring_nv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ring waveforms change on the falling edge; each rise is recorded by the clk edge that first samples it.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (period[c] < 3) begin
        ring_nv = 1'b0;
      end else begin
        ph[c] = (ph[c] + 1) % period[c];
        ring_nv = (ph[c] < period[c] / 2);
      end
      if (ring_nv && !ring[c]) begin
        if (c == 0) rises0.push_back(cyc + 1);
        else        rises1.push_back(cyc + 1);
      end
      ring[c] = ring_nv;
    end
  end

  ring_gate_counter #(.N_CH(2), .CNT_W(16), .GATE_W(16), .SYNC_FF(SYNC_FF)) dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring), .start(start), .mode(mode), .gate_len(gate_len),
`ifdef RING_CNT_HANDSHAKE_EN
    .ack(ack), .lost(lost),
`endif
    .value_out(value_out), .overflow(overflow), .valid(valid), .busy(busy));

  ring_gate_counter #(.N_CH(2), .CNT_W(4), .GATE_W(16), .SYNC_FF(SYNC_FF)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ring_in(ring), .start(start), .mode(mode), .gate_len(gate_len),
`ifdef RING_CNT_HANDSHAKE_EN
    .ack(ack), .lost(lost_sat),
`endif
    .value_out(value_sat), .overflow(ovf_sat), .valid(valid_sat), .busy(busy_sat));

  // A window starting at edge s with length len counts rises sampled at edges s+1-SYNC_FF .. s+len-SYNC_FF.
  function automatic int model_cnt(input int c, input int s, input int len);
    int n = 0;
    int lo = s + 1 - SYNC_FF;
    int hi = s + len - SYNC_FF;
    if (c == 0) begin
      foreach (rises0[i]) if (rises0[i] >= lo && rises0[i] <= hi) n++;
    end else begin
      foreach (rises1[i]) if (rises1[i] >= lo && rises1[i] <= hi) n++;
    end
    return n;
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int s;
    int vc = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({value_out, overflow, valid, busy} !== 36'd0) begin
      n_err++; $display("FAIL reset_initial: got %h expected 0", {value_out, overflow, valid, busy});
    end
    rst_n = 1'b1;
    period[0] = 4; period[1] = 7; mode = 1'b0; gate_len = 16'd100;
    repeat (10) @(negedge clk);
    pulse_start(s);
    repeat (30) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({value_out, overflow, valid, busy, value_sat, ovf_sat, valid_sat, busy_sat} !== 48'd0) begin
      n_err++; $display("FAIL reset_midwindow: got %h expected 0",
                        {value_out, overflow, valid, busy, value_sat, ovf_sat, valid_sat, busy_sat});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (valid || busy) vc++;
    end
    n_vec++;
    if (vc != 0 || value_out !== 32'd0) begin
      n_err++; $display("FAIL reset_no_valid: got %0d active cycles value %h expected 0 and 0", vc, value_out);
    end
    $display("reset: window aborted at cycle %0d", s + 30);
  endtask

  task automatic test_single();
    int s, bc, vc, vcyc, e0, e1;
    logic [31:0] v;
    logic [1:0] o;
    period[0] = 4; ph[0] = $urandom_range(0, 3);
    period[1] = 10; ph[1] = $urandom_range(0, 9);
    mode = 1'b0; gate_len = 16'd100;
    repeat (20) @(negedge clk);
    pulse_start(s);
    bc = busy ? 1 : 0; vc = 0; vcyc = -1; v = '0; o = '0;
    repeat (110) begin
      @(negedge clk);
      if (busy) bc++;
      if (valid) begin vc++; vcyc = cyc; v = value_out; o = overflow; end
    end
    e0 = model_cnt(0, s, 100); e1 = model_cnt(1, s, 100);
    $display("single: ch0=%0d ch1=%0d ovf=%b valid_at=%0d", v[15:0], v[31:16], o, vcyc - s);
    n_vec++;
    if (vc != 1 || vcyc != s + 101) begin
      n_err++; $display("FAIL single_valid: got %0d pulses at +%0d expected 1 at +101", vc, vcyc - s);
    end
    n_vec++;
    if (v[15:0] !== 16'(e0) || v[15:0] !== 16'd25) begin
      n_err++; $display("FAIL single_ch0: got %0d expected %0d (25)", v[15:0], e0);
    end
    n_vec++;
    if (v[31:16] !== 16'(e1) || v[31:16] !== 16'd10) begin
      n_err++; $display("FAIL single_ch1: got %0d expected %0d (10)", v[31:16], e1);
    end
    n_vec++;
    if (o !== 2'b00) begin n_err++; $display("FAIL single_ovf: got %b expected 00", o); end
    n_vec++;
    if (bc != 101) begin n_err++; $display("FAIL single_busy: got %0d cycles expected 101", bc); end
    n_vec++;
    if (value_out !== v) begin n_err++; $display("FAIL single_hold: got %h expected %h", value_out, v); end
  endtask

  task automatic test_continuous();
    int s, sw, vc, vcyc, e0, e1;
    logic [31:0] v;
    period[0] = 5; ph[0] = $urandom_range(0, 4);
    period[1] = $urandom_range(3, 12); ph[1] = 0;
    mode = 1'b1; gate_len = 16'd50;
    repeat (5) @(negedge clk);
    pulse_start(s);
    for (int w = 0; w < 3; w++) begin
      sw = s + 51 * w; vc = 0;
      while (cyc < sw + 51) begin
        @(negedge clk);
        if (valid && cyc != sw + 51) vc++;
      end
      e0 = model_cnt(0, sw, 50); e1 = model_cnt(1, sw, 50);
      $display("continuous window %0d: ch0=%0d ch1=%0d", w, value_out[15:0], value_out[31:16]);
      n_vec++;
      if (valid !== 1'b1 || vc != 0) begin
        n_err++; $display("FAIL cont_valid_%0d: got valid %b stray %0d expected 1 and 0", w, valid, vc);
      end
      n_vec++;
      if (value_out[15:0] !== 16'(e0) || e0 != 10 || value_out[31:16] !== 16'(e1)) begin
        n_err++; $display("FAIL cont_count_%0d: got %0d/%0d expected %0d/%0d", w,
                          value_out[15:0], value_out[31:16], e0, e1);
      end
    end
    repeat (10) @(negedge clk);
    mode = 1'b0;
    vc = 0; vcyc = -1; v = '0;
    repeat (120) begin
      @(negedge clk);
      if (valid) begin vc++; vcyc = cyc; v = value_out; end
    end
    e0 = model_cnt(0, s + 153, 50);
    $display("continuous stop: last ch0=%0d at +%0d", v[15:0], vcyc - s);
    n_vec++;
    if (vc != 1 || vcyc != s + 204 || v[15:0] !== 16'(e0)) begin
      n_err++; $display("FAIL cont_stop: got %0d pulses at +%0d ch0 %0d expected 1 at +204 ch0 %0d",
                        vc, vcyc - s, v[15:0], e0);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_saturation();
    int s, n0;
    int lens [2] = '{100, 40};
    period[0] = 4; ph[0] = $urandom_range(0, 3); period[1] = 0;
    mode = 1'b0;
    foreach (lens[k]) begin
      gate_len = 16'(lens[k]);
      repeat (4) @(negedge clk);
      pulse_start(s);
      while (cyc < s + lens[k] + 1) @(negedge clk);
      n0 = model_cnt(0, s, lens[k]);
      $display("saturation len=%0d: ch0=%0d ovf=%b", lens[k], value_sat[3:0], ovf_sat);
      n_vec++;
      if (valid_sat !== 1'b1 || value_sat[3:0] !== 4'(sat15(n0)) || value_sat[3:0] !== (k == 0 ? 4'd15 : 4'd10)) begin
        n_err++; $display("FAIL sat_count_%0d: got valid %b ch0 %0d expected 1 and %0d", lens[k],
                          valid_sat, value_sat[3:0], sat15(n0));
      end
      n_vec++;
      if (ovf_sat !== {1'b0, (n0 > 15)} || ovf_sat[0] !== (k == 0)) begin
        n_err++; $display("FAIL sat_ovf_%0d: got %b expected %b", lens[k], ovf_sat, {1'b0, (n0 > 15)});
      end
    end
  endtask

  task automatic test_boundaries();
    int s, s2, vc, vcyc;
    period[0] = 3; ph[0] = $urandom_range(0, 2); period[1] = 6;
    mode = 1'b0; gate_len = 16'd0;
    repeat (4) @(negedge clk);
    pulse_start(s);
    @(negedge clk);
    n_vec++;
    if (valid !== 1'b0) begin n_err++; $display("FAIL len0_early: got valid %b expected 0", valid); end
    @(negedge clk);
    $display("len0: valid=%b ch0=%0d", valid, value_out[15:0]);
    n_vec++;
    if (valid !== 1'b1 || value_out[15:0] !== 16'(model_cnt(0, s, 1))) begin
      n_err++; $display("FAIL len0_valid: got %b/%0d expected 1/%0d", valid, value_out[15:0], model_cnt(0, s, 1));
    end
    gate_len = 16'd30;
    repeat (3) @(negedge clk);
    pulse_start(s);
    repeat (8) @(negedge clk);
    pulse_start(s2);
    vc = 0; vcyc = -1;
    repeat (70) begin
      @(negedge clk);
      if (valid) begin vc++; vcyc = cyc; end
    end
    $display("start while busy: %0d pulses, second start at +%0d", vc, s2 - s);
    n_vec++;
    if (vc != 1 || vcyc != s + 31) begin
      n_err++; $display("FAIL busy_start: got %0d pulses at +%0d expected 1 at +31", vc, vcyc - s);
    end
  endtask

  task automatic test_random();
    int s, len, eff, vc, vcyc, n0, n1;
    logic [31:0] v;
    logic [1:0] o;
    logic [7:0] vs;
    logic [1:0] os;
    for (int it = 0; it < 6; it++) begin
      period[0] = $urandom_range(3, 12); period[1] = $urandom_range(3, 12);
      len = $urandom_range(0, 80); eff = (len == 0) ? 1 : len;
      mode = 1'b0; gate_len = 16'(len);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      pulse_start(s);
      gate_len = 16'($urandom);
      mode = 1'($urandom);
      vc = 0; vcyc = -1; v = '0; o = '0; vs = '0; os = '0;
      repeat (eff + 6) begin
        @(negedge clk);
        if (valid) begin vc++; vcyc = cyc; v = value_out; o = overflow; vs = value_sat; os = ovf_sat; end
      end
      mode = 1'b0;
      n0 = model_cnt(0, s, eff); n1 = model_cnt(1, s, eff);
      $display("random %0d: len=%0d periods=%0d/%0d ch0=%0d ch1=%0d sat=%0d/%0d", it, len,
               period[0], period[1], v[15:0], v[31:16], vs[3:0], vs[7:4]);
      n_vec++;
      if (vc != 1 || vcyc != s + eff + 1) begin
        n_err++; $display("FAIL rand_valid_%0d: got %0d pulses at +%0d expected 1 at +%0d", it, vc, vcyc - s, eff + 1);
      end
      n_vec++;
      if (v !== {16'(n1), 16'(n0)} || o !== 2'b00) begin
        n_err++; $display("FAIL rand_count_%0d: got %0d/%0d ovf %b expected %0d/%0d ovf 00", it,
                          v[15:0], v[31:16], o, n0, n1);
      end
      n_vec++;
      if (vs !== {4'(sat15(n1)), 4'(sat15(n0))} || os !== {1'(n1 > 15), 1'(n0 > 15)}) begin
        n_err++; $display("FAIL rand_sat_%0d: got %h ovf %b expected %0d/%0d", it, vs, os, sat15(n0), sat15(n1));
      end
    end
  endtask

`ifdef RING_CNT_HANDSHAKE_EN
  task automatic test_handshake();
    int s;
    period[0] = $urandom_range(3, 9); mode = 1'b1; gate_len = 16'd20; ack = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start(s);
    while (cyc < s + 21) @(negedge clk);
    n_vec++;
    if (valid !== 1'b1 || lost !== 1'b0) begin
      n_err++; $display("FAIL hs_first: got valid %b lost %b expected 1 0", valid, lost);
    end
    mode = 1'b0;
    while (cyc < s + 45) @(negedge clk);
    $display("handshake: valid=%b lost=%b ch0=%0d", valid, lost, value_out[15:0]);
    n_vec++;
    if (valid !== 1'b1 || lost !== 1'b1 || value_out[15:0] !== 16'(model_cnt(0, s + 21, 20))) begin
      n_err++; $display("FAIL hs_lost: got valid %b lost %b ch0 %0d expected 1 1 %0d", valid, lost,
                        value_out[15:0], model_cnt(0, s + 21, 20));
    end
    ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if (valid !== 1'b0 || lost !== 1'b0) begin
      n_err++; $display("FAIL hs_ack: got valid %b lost %b expected 0 0", valid, lost);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_saturation();
    test_boundaries();
    test_random();
`ifdef RING_CNT_HANDSHAKE_EN
    test_handshake();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
